led_pattern_sequencer: RTL and testbench
========================================

Name: led_pattern_sequencer

Overview:
- Controller for the 8-LED display path. It owns the step-rate prescaler and a mode state machine, and produces the LED pattern for four selectable display modes.
- Runs on the 1 MHz system clock.
- Mode changes come from a user "next mode" pulse. This pulse is already synchronized and single-cycle.
- The speed and pause inputs control when the pattern advances.
- led_out drives the board LEDs directly.

Parameters:
- N, 8, number of LEDs. Must be even and >= 4.
- TICK_DIV, 100000, clk cycles per pattern step at speed 0 (10 Hz at 1 MHz). Must be divisible by 8.
- DIV_W, 17, prescaler counter width. Must satisfy 2^DIV_W > TICK_DIV.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- next_mode  input  1  single-cycle pulse; advances the mode.
- pause  input  1  level; while high, the pattern is frozen.
- speed  input  2  step period = TICK_DIV >> speed (0: 1x, 1: 2x, 2: 4x, 3: 8x rate).
- led_out  output  N  registered LED pattern.
- mode  output  2  current mode: 0 SCAN, 1 FILL, 2 BLINK, 3 CENTER.
- step_tick  output  1  registered one-cycle pulse, high in the first cycle a new pattern is shown.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset values:
  - mode=0, led_out=1 (bit0 only), scan direction=up.
  - Prescaler cnt=0, step_tick=0.
- Prescaler:
  - term = (TICK_DIV >> speed) - 1, evaluated every cycle.
  - If pause=0 and cnt >= term: cnt <= 0 and a step occurs. Otherwise, if pause=0: cnt <= cnt+1.
  - If pause=1: cnt holds and no step occurs.
  - A speed change applies immediately. If cnt is already >= the new term, the step fires on the next cycle. There is no overshoot or wrap through 2^DIV_W.
- Step: on the edge where a step occurs, led_out updates to the next pattern and step_tick <= 1. step_tick is 0 on every other cycle.
- Mode FSM (on next_mode=1):
  - mode <= mode+1 mod 4.
  - led_out <= initial pattern of the new mode; direction resets to up; cnt <= 0; step_tick <= 0.
  - next_mode takes priority over a coincident step, which is dropped.
  - next_mode is honoured while pause=1 (the new initial pattern is shown, frozen).
- SCAN (mode 0):
  - Initial pattern 1, one-hot.
  - While direction is up: shift left. On reaching bit N-1, direction becomes down.
  - While direction is down: shift right. On reaching bit 0, direction becomes up.
  - Sequence of lit bit positions: 0,1,...,N-1,N-2,...,1,0,1,...; period 2N-2 steps. No bit is repeated at the ends.
- FILL (mode 1):
  - Initial pattern 0.
  - Each step: led <= {led[N-2:0],1'b1} until all ones. The step after all ones yields 0.
  - Period N+1 steps.
- BLINK (mode 2):
  - Initial pattern all ones.
  - Each step: led <= ~led.
  - Period 2 steps.
- CENTER (mode 3):
  - Initial pattern: bits N/2-1 and N/2 set.
  - Each step: the pair moves outward one position (lower bit down, upper bit up).
  - After bits 0 and N-1, the next step returns to the centre pair.
  - Period N/2 steps.
- Arithmetic:
  - Prescaler compare is unsigned, DIV_W bits; term is computed at DIV_W width.
  - mode wraps from 3 to 0.
- Reset mid-operation: immediate return to the reset values regardless of state; no step_tick is emitted.
- Outputs are glitch-free registers; there are no combinational paths from inputs to outputs.

Test Plan (N=8, TICK_DIV=8, DIV_W=4 for simulation):
1. Reset release, speed=0, pause=0 → first step_tick 8 cycles after release. led_out sequence 01,02,04,...,80,40,...,02,01,02; step_tick spacing exactly 8 cycles.
2. Speed sweep: at speed=3 → step_tick every cycle. Switching speed 0→2 while cnt=5 → step on the next cycle, then every 2 cycles.
3. Pause=1 for 20 cycles mid-FILL at led=07 → led_out stays 07 with no step_tick. After release → 0F exactly 8 cycles later (cnt had held).
4. next_mode pulses from reset → mode 1 with led=00, then 01,03,...,FF,00 on steps. Next pulse → mode 2 with led=FF, then 00. Next pulse → mode 3 with led=18, then 24,42,81,18. Next pulse → mode 0 with led=01.
5. next_mode in the same cycle as a step → no step_tick, led = new mode's initial pattern, next step 8 cycles later.
6. rst asserted mid-SCAN with direction down at led=20 → led_out=01, mode=0, step_tick=0 immediately (asynchronously). After release, the sequence restarts upward.

Source files
------------

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: step-rate prescaler plus a four-mode display FSM
// (scan, fill, blink, center-out) driving N registered LEDs.
module led_pattern_sequencer #(
  parameter int unsigned N        = 8,
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned DIV_W    = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         next_mode,
  input  logic         pause,
  input  logic [1:0]   speed,
  output logic [N-1:0] led_out,
  output logic [1:0]   mode,
  output logic         step_tick
);

  localparam logic [1:0] ModeScan   = 2'd0;
  localparam logic [1:0] ModeFill   = 2'd1;
  localparam logic [1:0] ModeBlink  = 2'd2;
  localparam logic [1:0] ModeCenter = 2'd3;

  localparam int unsigned       Half     = N / 2;
  localparam logic [DIV_W-1:0]  TickDivW = DIV_W'(TICK_DIV);
  localparam logic [N-1:0]      LedOne   = N'(1);

  logic [DIV_W-1:0] cnt_q, cnt_d, term;
  logic [N-1:0]     led_q, led_d, led_step, init_pat, center_pat;
  logic [1:0]       mode_q, mode_d, mode_nxt;
  logic             dir_down_q, dir_down_d, dir_step;
  logic             tick_q, tick_d, step;

  // Terminal count is re-evaluated every cycle so a speed change takes effect at once;
  // the >= compare fires immediately when cnt already exceeds a smaller term.
  assign term     = (TickDivW >> speed) - DIV_W'(1);
  assign step     = !pause && (cnt_q >= term);
  assign mode_nxt = mode_q + 2'd1;

  always_comb begin
    center_pat           = '0;
    center_pat[Half-1]   = 1'b1;
    center_pat[Half]     = 1'b1;
  end

  always_comb begin
    init_pat = '0;
    unique case (mode_nxt)
      ModeScan:   init_pat = LedOne;
      ModeFill:   init_pat = '0;
      ModeBlink:  init_pat = '1;
      ModeCenter: init_pat = center_pat;
    endcase
  end

  always_comb begin
    led_step = led_q;
    dir_step = dir_down_q;
    unique case (mode_q)
      ModeScan: begin
        // Direction flips on arrival at an end so the end bit is shown only once.
        if (!dir_down_q) begin
          led_step = led_q << 1;
          if (led_step[N-1]) dir_step = 1'b1;
        end else begin
          led_step = led_q >> 1;
          if (led_step[0]) dir_step = 1'b0;
        end
      end
      ModeFill:   led_step = (&led_q) ? '0 : {led_q[N-2:0], 1'b1};
      ModeBlink:  led_step = ~led_q;
      ModeCenter: begin
        if (led_q[0]) led_step = center_pat;
        else          led_step = {led_q[N-1:Half] << 1, led_q[Half-1:0] >> 1};
      end
    endcase
  end

  always_comb begin
    mode_d     = mode_q;
    led_d      = led_q;
    dir_down_d = dir_down_q;
    cnt_d      = cnt_q;
    tick_d     = 1'b0;
    if (next_mode) begin
      // A mode change swallows any coincident step and restarts the prescaler.
      mode_d     = mode_nxt;
      led_d      = init_pat;
      dir_down_d = 1'b0;
      cnt_d      = '0;
    end else if (!pause) begin
      if (step) begin
        cnt_d      = '0;
        led_d      = led_step;
        dir_down_d = dir_step;
        tick_d     = 1'b1;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= ModeScan;
      led_q      <= LedOne;
      dir_down_q <= 1'b0;
      cnt_q      <= '0;
      tick_q     <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      led_q      <= led_d;
      dir_down_q <= dir_down_d;
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
    end
  end

  assign led_out   = led_q;
  assign mode      = mode_q;
  assign step_tick = tick_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: directed test-plan steps followed by a random phase,
// all checked against a step-index based reference model.
module tb_led_pattern_sequencer;

  localparam int N        = 8;
  localparam int TICK_DIV = 8;
  localparam int DIV_W    = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         next_mode = 1'b0;
  logic         pause = 1'b0;
  logic [1:0]   speed = 2'd0;
  logic [N-1:0] led_out;
  logic [1:0]   mode;
  logic         step_tick;

  int checks = 0;
  int errors = 0;

  // Reference model: mode, number of steps taken in this mode, prescaler count, tick.
  int m_mode = 0;
  int m_k    = 0;
  int m_cnt  = 0;
  bit m_tick = 1'b0;

  led_pattern_sequencer #(
    .N        (N),
    .TICK_DIV (TICK_DIV),
    .DIV_W    (DIV_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .next_mode (next_mode),
    .pause     (pause),
    .speed     (speed),
    .led_out   (led_out),
    .mode      (mode),
    .step_tick (step_tick)
  );

  always #5 clk = ~clk;

  // Pattern as a pure function of mode and step index since mode entry.
  function automatic logic [N-1:0] exp_led(int md, int k);
    logic [N-1:0] v;
    int p;
    v = '0;
    case (md)
      0: begin
        p = k % (2 * N - 2);
        if (p >= N) p = 2 * N - 2 - p;
        v[p] = 1'b1;
      end
      1: begin
        p = k % (N + 1);
        v = N'((1 << p) - 1);
      end
      2: v = (k % 2 == 0) ? '1 : '0;
      default: begin
        p = k % (N / 2);
        v[N/2 - 1 - p] = 1'b1;
        v[N/2 + p]     = 1'b1;
      end
    endcase
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_k    = 0;
    m_cnt  = 0;
    m_tick = 1'b0;
  endtask

  // Advance the model with the current inputs, take one clock edge, compare outputs.
  task automatic tick_cycle();
    int term;
    term = (TICK_DIV >> speed) - 1;
    if (rst) begin
      model_reset();
    end else if (next_mode) begin
      m_mode = (m_mode + 1) % 4;
      m_k    = 0;
      m_cnt  = 0;
      m_tick = 1'b0;
    end else if (pause) begin
      m_tick = 1'b0;
    end else if (m_cnt >= term) begin
      m_cnt  = 0;
      m_k++;
      m_tick = 1'b1;
    end else begin
      m_cnt++;
      m_tick = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("model_led", 32'(led_out), 32'(exp_led(m_mode, m_k)));
    chk("model_mode", 32'(mode), 32'(m_mode));
    chk("model_tick", 32'(step_tick), 32'(m_tick));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick_cycle();
  endtask

  task automatic pulse_next();
    next_mode = 1'b1;
    tick_cycle();
    next_mode = 1'b0;
  endtask

  initial begin
    int guard;

    // Reset values
    #12;
    chk("reset_led", 32'(led_out), 32'h01);
    chk("reset_mode", 32'(mode), 32'd0);
    chk("reset_tick", 32'(step_tick), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: first step 8 cycles after release, then the scan bounce
    run(7);
    chk("no_early_tick", 32'(step_tick), 32'd0);
    tick_cycle();
    chk("first_tick", 32'(step_tick), 32'd1);
    chk("first_led", 32'(led_out), 32'h02);
    run(8 * 15);

    // 2: speed sweep
    speed = 2'd3;
    for (int i = 0; i < 4; i++) begin
      tick_cycle();
      chk("speed3_tick", 32'(step_tick), 32'd1);
    end
    speed = 2'd0;
    run(5);
    speed = 2'd2;
    tick_cycle();
    chk("speed_switch_tick", 32'(step_tick), 32'd1);
    tick_cycle();
    chk("speed2_gap", 32'(step_tick), 32'd0);
    tick_cycle();
    chk("speed2_tick", 32'(step_tick), 32'd1);
    speed = 2'd0;

    // 3: pause mid-fill at 07
    rst = 1'b1;
    tick_cycle();
    rst = 1'b0;
    pulse_next();
    chk("fill_mode", 32'(mode), 32'd1);
    chk("fill_init", 32'(led_out), 32'h00);
    guard = 0;
    while (!(m_k == 3 && m_tick) && guard < 100) begin
      tick_cycle();
      guard++;
    end
    chk("fill_07", 32'(led_out), 32'h07);
    pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick_cycle();
      chk("pause_led", 32'(led_out), 32'h07);
      chk("pause_tick", 32'(step_tick), 32'd0);
    end
    pause = 1'b0;
    run(7);
    chk("unpause_wait", 32'(step_tick), 32'd0);
    tick_cycle();
    chk("unpause_tick", 32'(step_tick), 32'd1);
    chk("unpause_led", 32'(led_out), 32'h0F);

    // 4: walk through remaining modes
    run(8 * 6);
    pulse_next();
    chk("blink_mode", 32'(mode), 32'd2);
    chk("blink_init", 32'(led_out), 32'hFF);
    run(8);
    chk("blink_step", 32'(led_out), 32'h00);
    pulse_next();
    chk("center_mode", 32'(mode), 32'd3);
    chk("center_init", 32'(led_out), 32'h18);
    run(8 * 4);
    pulse_next();
    chk("scan_mode", 32'(mode), 32'd0);
    chk("scan_init", 32'(led_out), 32'h01);

    // 5: next_mode coincident with a step
    guard = 0;
    while (m_cnt != TICK_DIV - 1 && guard < 20) begin
      tick_cycle();
      guard++;
    end
    pulse_next();
    chk("coinc_tick", 32'(step_tick), 32'd0);
    chk("coinc_led", 32'(led_out), 32'h00);
    run(7);
    chk("coinc_wait", 32'(step_tick), 32'd0);
    tick_cycle();
    chk("coinc_next_tick", 32'(step_tick), 32'd1);

    // 6: async reset mid-scan heading down at 20
    pulse_next();
    pulse_next();
    pulse_next();
    guard = 0;
    while (m_k != 9 && guard < 200) begin
      tick_cycle();
      guard++;
    end
    chk("scan_down_20", 32'(led_out), 32'h20);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_led", 32'(led_out), 32'h01);
    chk("async_rst_mode", 32'(mode), 32'd0);
    chk("async_rst_tick", 32'(step_tick), 32'd0);
    tick_cycle();
    rst = 1'b0;
    run(8);
    chk("restart_up", 32'(led_out), 32'h02);
    run(16);

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      next_mode = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) pause = ~pause;
      if ($urandom_range(0, 19) == 0) speed = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 199) == 0);
      tick_cycle();
    end
    next_mode = 1'b0;
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
